// File: rtl/counter_pkg.sv
// counter_pkg: boundary-mode type shared by the counter and its bench.
package counter_pkg;
   typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that emits one tick every DIV enabled cycles.
module tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);
   logic [PW-1:0] pre;
   if (DIV < 1) begin : g_bad_div
      $error("tick_gen: DIV must be >= 1");
   end
   assign tick = en && (pre == LAST);
   always_ff @(posedge clk or posedge rst)
      if (rst) pre <= '0;
      else if (sync_clr) pre <= '0;
      else if (en) pre <= tick ? '0 : pre + 1'b1;
endmodule

// File: rtl/mod_counter.sv
// mod_counter: prescaled modulo up/down counter with wrap or saturate
// boundary handling and a registered terminal-count pulse.
module mod_counter
   import counter_pkg::*;
#(
   parameter int    WIDTH   = 4,
   parameter int    MODULUS = 16,
   parameter int    DIV     = 1,
   parameter mode_t MODE    = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
   if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) || DIV < 1) begin : g_bad_param
      $error("mod_counter: illegal MODULUS or DIV");
   end
   logic             tick, at_edge;
   logic [WIDTH-1:0] step, nxt, lim;
   tick_gen #(.DIV(DIV)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync_clr (clr | load),
      .tick     (tick)
   );
   // at_edge marks a boundary step; nxt is the value taken on a tick
   always_comb begin
      at_edge = up ? (count == MAX) : (count == '0);
      step    = up ? count + 1'b1 : count - 1'b1;
      nxt     = at_edge ? ((MODE == MODE_SAT) ? count : (up ? '0 : MAX)) : step;
      lim     = (load_val > MAX) ? MAX : load_val;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (load) begin
         count <= lim;
         tc    <= 1'b0;
      end else if (tick) begin
         count <= nxt;
         tc    <= at_edge;
      end else
         tc <= 1'b0;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed vector table plus hand sequences over four
// counter configurations sharing one set of inputs.
module tb_mod_counter;
   import counter_pkg::*;
   logic       clk = 1'b0, rst = 1'b1;
   logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] c_w, c_s, c_d, c_f;
   logic       t_w, t_s, t_d, t_f;
   int         n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(4), .MODULUS(10), .DIV(1), .MODE(MODE_WRAP)) u_w (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .count(c_w), .tc(t_w));
   mod_counter #(.WIDTH(4), .MODULUS(10), .DIV(1), .MODE(MODE_SAT)) u_s (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .count(c_s), .tc(t_s));
   mod_counter #(.WIDTH(4), .MODULUS(10), .DIV(3), .MODE(MODE_WRAP)) u_d (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .count(c_d), .tc(t_d));
   mod_counter #(.WIDTH(4), .MODULUS(16), .DIV(1), .MODE(MODE_WRAP)) u_f (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .count(c_f), .tc(t_f));

   typedef struct {
      logic       en, up, clr, load;
      logic [3:0] lv;
      logic [3:0] cnt;
      logic       tc;
   } vec_t;
   vec_t vt[27];

   task automatic check(input string name, input logic [3:0] ac, input logic at,
                        input logic [3:0] ec, input logic et);
      n_chk += 2;
      if (ac !== ec) begin
         n_fail++;
         $display("FAIL %s count: got %0d expected %0d", name, ac, ec);
      end
      if (at !== et) begin
         n_fail++;
         $display("FAIL %s tc: got %0b expected %0b", name, at, et);
      end
   endtask

   task automatic edge1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
      #1;
      check("reset_w", c_w, t_w, 4'd0, 1'b0);
      edge1();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 12; i++)
         vt[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'((i + 1) % 10), (i == 9)};
      vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd2, 1'b0};
      vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  4'd9, 1'b0};
      vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b1};
      vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1};
      vt[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd8, 1'b0};
      vt[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0};
      vt[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0};
      vt[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  4'd0, 1'b0};
      vt[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1};
      vt[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd8, 1'b0};
      vt[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd7, 1'b0};
      vt[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0, 1'b0};
      vt[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0, 1'b0};
      vt[25] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9,  4'd9, 1'b0};
      vt[26] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  4'd2, 1'b0};

      // wrap counter, DIV=1: vector table
      do_reset();
      for (int i = 0; i < 27; i++) begin
         en = vt[i].en; up = vt[i].up; clr = vt[i].clr; load = vt[i].load; load_val = vt[i].lv;
         edge1();
         check($sformatf("vec%0d", i), c_w, t_w, vt[i].cnt, vt[i].tc);
      end

      // saturating counter and full-range (MODULUS=16) wrap
      do_reset();
      load = 1'b1; load_val = 4'd15;
      edge1();
      check("sat_load", c_s, t_s, 4'd9, 1'b0);
      check("full_load", c_f, t_f, 4'd15, 1'b0);
      load = 1'b0; en = 1'b1; up = 1'b1;
      edge1();
      check("sat_up1", c_s, t_s, 4'd9, 1'b1);
      check("full_wrap_up", c_f, t_f, 4'd0, 1'b1);
      edge1();
      check("sat_up2", c_s, t_s, 4'd9, 1'b1);
      edge1();
      check("sat_up3", c_s, t_s, 4'd9, 1'b1);
      up = 1'b0;
      edge1();
      check("sat_dn", c_s, t_s, 4'd8, 1'b0);
      en = 1'b0; load = 1'b1; load_val = 4'd0;
      edge1();
      check("sat_load0", c_s, t_s, 4'd0, 1'b0);
      load = 1'b0; en = 1'b1; up = 1'b0;
      edge1();
      check("sat_low", c_s, t_s, 4'd0, 1'b1);
      check("full_wrap_dn", c_f, t_f, 4'd15, 1'b1);
      up = 1'b1;
      edge1();
      check("sat_leave", c_s, t_s, 4'd1, 1'b0);

      // DIV=3 prescale, en stall and direction change mid-prescale
      do_reset();
      en = 1'b1; up = 1'b1;
      begin
         logic [3:0] exp_d[7];
         exp_d = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
         for (int i = 0; i < 7; i++) begin
            edge1();
            check($sformatf("div3_e%0d", i + 1), c_d, t_d, exp_d[i], 1'b0);
         end
      end
      en = 1'b0;
      edge1();
      check("div3_stall1", c_d, t_d, 4'd2, 1'b0);
      edge1();
      check("div3_stall2", c_d, t_d, 4'd2, 1'b0);
      en = 1'b1;
      edge1();
      check("div3_resume1", c_d, t_d, 4'd2, 1'b0);
      edge1();
      check("div3_resume2", c_d, t_d, 4'd3, 1'b0);
      up = 1'b0;
      edge1();
      check("div3_dir1", c_d, t_d, 4'd3, 1'b0);
      up = 1'b1;
      edge1();
      check("div3_dir2", c_d, t_d, 4'd3, 1'b0);
      edge1();
      check("div3_dir3", c_d, t_d, 4'd4, 1'b0);

      // asynchronous reset mid-prescale at count 7
      en = 1'b0; load = 1'b1; load_val = 4'd7;
      edge1();
      load = 1'b0; en = 1'b1;
      edge1();
      check("arst_pre", c_d, t_d, 4'd7, 1'b0);
      #3 rst = 1'b1;
      #1;
      check("arst_d", c_d, t_d, 4'd0, 1'b0);
      check("arst_w", c_w, t_w, 4'd0, 1'b0);
      #1 rst = 1'b0;
      edge1();
      check("arst_r1", c_d, t_d, 4'd0, 1'b0);
      edge1();
      check("arst_r2", c_d, t_d, 4'd0, 1'b0);
      edge1();
      check("arst_r3", c_d, t_d, 4'd1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: count width in bits.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter DIV, default 1: prescale ratio, i.e. enabled cycles per count step; legal value >= 1.
REQ-004 Parameter MODE, default MODE_WRAP: MODE_WRAP or MODE_SAT, with values from the package.
REQ-005 Port clk, input, 1 bit: single clock, rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port en, input, 1 bit: count enable, feeds the prescaler.
REQ-008 Port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-009 Port clr, input, 1 bit: synchronous clear.
REQ-010 Port load, input, 1 bit: synchronous load of load_val.
REQ-011 Port load_val, input, WIDTH bits: value to load.
REQ-012 Port count, output, WIDTH bits: registered count value.
REQ-013 Port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-014 Illegal MODULUS or DIV SHALL cause an elaboration-time error.
REQ-015 Per-edge priority SHALL be: clr > load > tick > hold.
REQ-016 clr SHALL set count to 0 and prescaler to 0; tc SHALL be 0 the next cycle.
REQ-017 load SHALL set count to min(load_val, MODULUS-1), set prescaler to 0 and force tc to 0.
REQ-018 Prescaler SHALL be a counter 0..DIV-1 that advances only when en=1.
  - tick = en AND (prescaler == DIV-1).
  - Prescaler wraps to 0 on tick.
  - DIV=1: tick = en.
REQ-019 With en=0, count and prescaler SHALL hold.
REQ-020 up does not affect the prescaler; a direction change mid-prescale SHALL NOT reset it.
REQ-021 On tick with up=1 and count < MODULUS-1: count SHALL become count+1.
REQ-022 On tick with up=0 and count > 0: count SHALL become count-1.
REQ-023 MODE_WRAP boundaries:
  - tick, up=1, count = MODULUS-1: count -> 0, tc = 1.
  - tick, up=0, count = 0: count -> MODULUS-1, tc = 1.
REQ-024 MODE_SAT boundaries:
  - tick, up=1, count = MODULUS-1: count holds, tc = 1.
  - tick, up=0, count = 0: count holds, tc = 1.
  - tc SHALL re-pulse on every further blocked tick.
REQ-025 In all other cycles tc SHALL be 0; tc is high exactly one cycle per boundary event.
REQ-026 Latency: count and tc SHALL reflect a tick on the clock edge where the tick occurs (one-cycle register latency); there is no combinational input-to-output path.
REQ-027 Arithmetic SHALL be performed in WIDTH bits; count SHALL never exceed MODULUS-1, including when MODULUS = 2**WIDTH.
REQ-028 Simultaneous clr/load with tick: the tick is discarded and no tc is raised.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force count=0, tc=0 and prescaler=0, including mid-prescale or mid-count.
REQ-030 Counting SHALL resume on the first rising edge with rst=0 and a tick.
REQ-031 The prescaler SHALL restart from 0 after reset release.

Structure
REQ-032 Package counter_pkg SHALL hold the MODE_WRAP and MODE_SAT constants and the mode type.
REQ-033 The prescaler SHALL be a sub-module named tick_gen.
  - Parameter: DIV.
  - Ports: clk, rst, en, sync_clr, tick.
  - sync_clr is driven by clr OR load.
REQ-034 mod_counter SHALL contain the count register, boundary logic and tc register only.

Verification
REQ-035 WIDTH=4, MODULUS=10, DIV=1, WRAP, up=1, en=1 for 12 cycles after reset:
  - Expect count 1..9, 0, 1, 2.
  - Expect tc=1 only in the cycle count shows 0.
REQ-036 Same configuration, up=0 from count=0:
  - Expect count 9, 8, ...
  - Expect tc=1 in the cycle count shows 9.
REQ-037 MODULUS=10, SAT, load_val=15 with load=1, then up=1 for 3 ticks:
  - Expect count=9 after the load and holding at 9.
  - Expect tc=1 on each of the 3 ticks.
REQ-038 DIV=3, en=1 continuously:
  - Expect count to step every 3rd cycle.
  - Toggling en=0 for 2 cycles mid-prescale delays the next step by exactly 2 cycles.
REQ-039 clr and load asserted together with count=5: expect count=0 next cycle and tc=0.
REQ-040 Assert rst asynchronously (between clock edges) at count=7, DIV=3: expect count=0 before the next edge, then counting restarts with a full 3-cycle prescale.
